alk_muldiv_seq: RTL and testbench

ALK_MULDIV_SEQ -- requirements
Module: alk_muldiv_seq

---
 rtl/alk_muldiv_seq.sv | 138 +++++++++++++
 tb/tb_alk_muldiv_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alk_muldiv_seq.sv
// Multiply/divide step sequencer: counts ALU iteration steps and flags loop, fix and done phases.
// Latency: N steps (8/16/32) + optional divide restore cycle + one DONE cycle; outputs registered.
// Backpressure: stall_h freezes state and step count (except DONE); abort_h returns to IDLE at once.
module alk_muldiv_seq (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       start_h,
    input  logic       op_div_h,
    input  logic [1:0] dsize_h,
    input  logic       c32_in_h,
    input  logic       stall_h,
    input  logic       abort_h,
    output logic       busy_h,
    output logic       loopf_h,
    output logic       alpctl_mul_l,
    output logic       alpctl_mul_group_h,
    output logic [5:0] step_cnt_h,
    output logic       last_step_h,
    output logic       div_fix_h,
    output logic       done_h
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_LOOP = 3'd1,
        S_DIV_LOOP = 3'd2,
        S_DIV_FIX  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t     r_state;
    logic [5:0] r_cnt;
    logic       r_busy;
    logic       r_loopf;
    logic       r_mul_l;
    logic       r_mul_group;
    logic       r_last;
    logic       r_fix;
    logic       r_done;

    state_t     w_nxt_state;
    logic [5:0] w_nxt_cnt;
    logic [5:0] w_load_cnt;
    logic       w_nxt_loop;

    // Step count loaded at start: byte, word, long (size code 11 behaves as long)
    always_comb begin
        case (dsize_h)
            2'b00:   w_load_cnt = 6'd8;
            2'b01:   w_load_cnt = 6'd16;
            default: w_load_cnt = 6'd32;
        endcase
    end

    // Next state and count; abort wins over everything, stall freezes all but DONE
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        if (abort_h) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_h && !stall_h) begin
                        w_nxt_state = op_div_h ? S_DIV_LOOP : S_MUL_LOOP;
                        w_nxt_cnt   = w_load_cnt;
                    end
                end
                S_MUL_LOOP, S_DIV_LOOP: begin
                    if (!stall_h) begin
                        if (r_cnt > 6'd1) begin
                            w_nxt_cnt = r_cnt - 6'd1;
                        end else begin
                            w_nxt_cnt = 6'd0;
                            // Divide with no carry out on the final step needs a remainder restore
                            if (r_state == S_DIV_LOOP && !c32_in_h) begin
                                w_nxt_state = S_DIV_FIX;
                            end else begin
                                w_nxt_state = S_DONE;
                            end
                        end
                    end
                end
                S_DIV_FIX: begin
                    if (!stall_h) begin
                        w_nxt_state = S_DONE;
                    end
                end
                S_DONE: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = 6'd0;
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = 6'd0;
                end
            endcase
        end
    end

    assign w_nxt_loop = (w_nxt_state == S_MUL_LOOP) || (w_nxt_state == S_DIV_LOOP);

    // State, counter and outputs registered together so outputs never see inputs combinationally
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state     <= S_IDLE;
            r_cnt       <= 6'd0;
            r_busy      <= 1'b0;
            r_loopf     <= 1'b0;
            r_mul_l     <= 1'b1;
            r_mul_group <= 1'b0;
            r_last      <= 1'b0;
            r_fix       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_busy      <= (w_nxt_state != S_IDLE);
            r_loopf     <= w_nxt_loop;
            r_mul_l     <= (w_nxt_state != S_MUL_LOOP);
            r_mul_group <= (w_nxt_state == S_DIV_LOOP) || (w_nxt_state == S_DIV_FIX);
            r_last      <= w_nxt_loop && (w_nxt_cnt == 6'd1);
            r_fix       <= (w_nxt_state == S_DIV_FIX);
            r_done      <= (w_nxt_state == S_DONE);
        end
    end

    assign busy_h             = r_busy;
    assign loopf_h            = r_loopf;
    assign alpctl_mul_l       = r_mul_l;
    assign alpctl_mul_group_h = r_mul_group;
    assign step_cnt_h         = r_cnt;
    assign last_step_h        = r_last;
    assign div_fix_h          = r_fix;
    assign done_h             = r_done;

endmodule

// File: tb/tb_alk_muldiv_seq.sv
// Randomized bench for alk_muldiv_seq: per-operation expected trace built from step counts.
// Checks every cycle of each operation plus reset, abort, stall and ignored-start cases.
// Inputs driven #1 after the rising edge; outputs sampled at the same point before driving.
module tb_alk_muldiv_seq;

    logic       clk;
    logic       reset_l;
    logic       start_h;
    logic       op_div_h;
    logic [1:0] dsize_h;
    logic       c32_in_h;
    logic       stall_h;
    logic       abort_h;
    logic       busy_h;
    logic       loopf_h;
    logic       alpctl_mul_l;
    logic       alpctl_mul_group_h;
    logic [5:0] step_cnt_h;
    logic       last_step_h;
    logic       div_fix_h;
    logic       done_h;

    int n_tests;
    int n_fail;

    // Expected trace of one operation: phase kind and count per cycle, plus the inputs to apply
    localparam int K_IDLE = 0;
    localparam int K_MUL  = 1;
    localparam int K_DIV  = 2;
    localparam int K_FIX  = 3;
    localparam int K_DONE = 4;

    int q_kind[$];
    int q_cnt[$];
    bit q_stall[$];
    bit q_c32[$];
    bit q_abort[$];

    alk_muldiv_seq dut (
        .clk               (clk),
        .reset_l           (reset_l),
        .start_h           (start_h),
        .op_div_h          (op_div_h),
        .dsize_h           (dsize_h),
        .c32_in_h          (c32_in_h),
        .stall_h           (stall_h),
        .abort_h           (abort_h),
        .busy_h            (busy_h),
        .loopf_h           (loopf_h),
        .alpctl_mul_l      (alpctl_mul_l),
        .alpctl_mul_group_h(alpctl_mul_group_h),
        .step_cnt_h        (step_cnt_h),
        .last_step_h       (last_step_h),
        .div_fix_h         (div_fix_h),
        .done_h            (done_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output pattern implied by a phase: {busy,loopf,mul_l,mul_group,cnt[5:0],last,fix,done}
    function automatic logic [12:0] exp_vec(input int kind, input int cnt);
        logic in_loop;
        in_loop = (kind == K_MUL) || (kind == K_DIV);
        return {kind != K_IDLE, in_loop, kind != K_MUL, (kind == K_DIV) || (kind == K_FIX),
                6'(cnt), in_loop && (cnt == 1), kind == K_FIX, kind == K_DONE};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {busy_h, loopf_h, alpctl_mul_l, alpctl_mul_group_h, step_cnt_h,
                last_step_h, div_fix_h, done_h};
    endfunction

    task automatic push(input int kind, input int cnt, input bit stl, input bit c32, input bit ab);
        q_kind.push_back(kind);
        q_cnt.push_back(cnt);
        q_stall.push_back(stl);
        q_c32.push_back(c32);
        q_abort.push_back(ab);
    endtask

    function automatic int rnd_stalls(input int pct);
        if (int'($urandom_range(0, 99)) < pct) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    // One operation from IDLE: build expected trace, then drive it and compare every cycle
    task automatic run_txn(input bit op, input logic [1:0] sz, input bit c32f, input int pct,
                           input int stall_at, input int stall_n, input int abort_cnt,
                           output int busy_cnt);
        int  n;
        int  kind;
        int  ns;
        bit  ab;
        n    = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
        kind = op ? K_DIV : K_MUL;
        ab   = 1'b0;
        q_kind.delete(); q_cnt.delete(); q_stall.delete(); q_c32.delete(); q_abort.delete();
        for (int c = n; c >= 1; c--) begin
            if (!ab) begin
                if (c == abort_cnt) begin
                    push(kind, c, 1'b1, 1'b0, 1'b1);
                    ab = 1'b1;
                end else begin
                    ns = (c == stall_at) ? stall_n : rnd_stalls(pct);
                    for (int s = 0; s < ns; s++) push(kind, c, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                    push(kind, c, 1'b0, (c == 1) ? c32f : 1'($urandom_range(0, 1)), 1'b0);
                end
            end
        end
        if (!ab) begin
            if (op && !c32f) begin
                ns = rnd_stalls(pct);
                for (int s = 0; s < ns; s++) push(K_FIX, 0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                push(K_FIX, 0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            push(K_DONE, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        start_h  = 1'b1;
        op_div_h = op;
        dsize_h  = sz;
        stall_h  = 1'b0;
        abort_h  = 1'b0;
        c32_in_h = 1'b0;
        @(posedge clk); #1;
        start_h  = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < q_kind.size(); k++) begin
            check_eq($sformatf("trace op=%0d sz=%0d k=%0d", op, sz, k), 32'(obs_vec()),
                     32'(exp_vec(q_kind[k], q_cnt[k])));
            if (busy_h) busy_cnt++;
            stall_h  = q_stall[k];
            c32_in_h = q_c32[k];
            abort_h  = q_abort[k];
            start_h  = (q_kind[k] == K_DONE) ? 1'b1 : 1'($urandom_range(0, 1));
            op_div_h = 1'($urandom_range(0, 1));
            dsize_h  = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        start_h = 1'b0;
        stall_h = 1'b0;
        abort_h = 1'b0;
        check_eq("idle_after", 32'(obs_vec()), 32'(exp_vec(K_IDLE, 0)));
        check_eq("busy_cycles", busy_cnt, q_kind.size());
        @(posedge clk); #1;
        check_eq("idle_settled", 32'(obs_vec()), 32'(exp_vec(K_IDLE, 0)));
    endtask

    initial begin
        int bc;
        bit op;
        logic [1:0] sz;
        n_tests  = 0;
        n_fail   = 0;
        reset_l  = 1'b0;
        start_h  = 1'b0;
        op_div_h = 1'b0;
        dsize_h  = 2'b00;
        c32_in_h = 1'b0;
        stall_h  = 1'b0;
        abort_h  = 1'b0;

        #7;
        check_eq("reset_vals", 32'(obs_vec()), 32'(exp_vec(K_IDLE, 0)));
        @(negedge clk) reset_l = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_post_reset", 32'(obs_vec()), 32'(exp_vec(K_IDLE, 0)));

        // start while stalled in IDLE is not taken
        start_h = 1'b1; stall_h = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_stall_start", 32'(obs_vec()), 32'(exp_vec(K_IDLE, 0)));
        // abort beats start in IDLE
        stall_h = 1'b0; abort_h = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_abort_start", 32'(obs_vec()), 32'(exp_vec(K_IDLE, 0)));
        start_h = 1'b0; abort_h = 1'b0;

        // long multiply, no stall: 32 loop cycles + DONE
        run_txn(1'b0, 2'b10, 1'b0, 0, 0, 0, 0, bc);
        check_eq("long_mul_busy", bc, 33);
        // byte divide with and without the restore cycle
        run_txn(1'b1, 2'b00, 1'b0, 0, 0, 0, 0, bc);
        check_eq("byte_div_fix_busy", bc, 10);
        run_txn(1'b1, 2'b00, 1'b1, 0, 0, 0, 0, bc);
        check_eq("byte_div_nofix_busy", bc, 9);
        // word multiply stalled 3 cycles at count 5
        run_txn(1'b0, 2'b01, 1'b0, 0, 5, 3, 0, bc);
        check_eq("word_mul_stall_busy", bc, 20);
        // abort together with stall at count 10
        run_txn(1'b0, 2'b10, 1'b0, 0, 0, 0, 10, bc);
        check_eq("abort_busy", bc, 23);
        // size code 11 runs as long
        run_txn(1'b1, 2'b11, 1'b1, 0, 0, 0, 0, bc);
        check_eq("size11_busy", bc, 33);

        // reset mid-loop: outputs drop without a clock edge, no done afterwards
        start_h = 1'b1; op_div_h = 1'b1; dsize_h = 2'b10;
        @(posedge clk); #1;
        start_h = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_l = 1'b0;
        #1;
        check_eq("async_reset_mid", 32'(obs_vec()), 32'(exp_vec(K_IDLE, 0)));
        @(negedge clk) reset_l = 1'b1;
        @(posedge clk); #1;
        check_eq("after_reset_idle", 32'(obs_vec()), 32'(exp_vec(K_IDLE, 0)));
        run_txn(1'b0, 2'b00, 1'b0, 0, 0, 0, 0, bc);
        check_eq("post_reset_mul_busy", bc, 9);

        // randomized operations with random stalls and occasional aborts
        for (int t = 0; t < 30; t++) begin
            op = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            run_txn(op, sz, 1'($urandom_range(0, 1)), 30, 0, 0,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0, bc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
